// File: rtl/gl_prim_assembler.sv
// Primitive assembly: groups incoming vertices into points/lines/triangles/strips
// and queues finished primitives in a small FIFO for the raster front end.
module gl_prim_assembler #(
    parameter int PW    = 96,
    parameter int CW    = 96,
    parameter int DEPTH = 4,
    parameter int SW    = PW + CW
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [1:0]                   mode,
    input  logic                         begin_prim,
    input  logic                         vert_valid,
    output logic                         vert_ready,
    input  logic [PW-1:0]                vert_pos,
    input  logic [CW-1:0]                vert_color,
    output logic                         prim_valid,
    input  logic                         prim_ready,
    output logic [3*SW-1:0]              prim_data,
    output logic [1:0]                   prim_nverts,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
    output logic [15:0]                  prim_total
);
    localparam int AW   = $clog2(DEPTH);
    localparam int CNTW = $clog2(DEPTH+1);

    typedef enum logic [1:0] {M_POINTS, M_LINES, M_TRIS, M_STRIP} mode_t;

    typedef struct packed {
        logic [1:0]      nverts;
        logic [3*SW-1:0] data;
    } prim_t;

    mode_t           mode_r;
    logic [SW-1:0]   v0, v1;
    logic [1:0]      vcnt;
    logic            par;

    prim_t           mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;

    logic            accept, pop, push;
    logic [SW-1:0]   vtx;
    prim_t           push_entry, head;
    mode_t           eff_mode;
    logic [1:0]      eff_vcnt;
    logic            eff_par;
    logic [SW-1:0]   v0_n, v1_n;
    logic [1:0]      vcnt_n;
    logic            par_n;

    assign vert_ready = (fifo_count != CNTW'(DEPTH));
    assign prim_valid = (fifo_count != '0);
    assign accept     = vert_valid & vert_ready;
    assign pop        = prim_valid & prim_ready;
    assign vtx        = {vert_pos, vert_color};

    // begin_prim takes effect before a vertex accepted in the same cycle
    assign eff_mode = begin_prim ? mode_t'(mode) : mode_r;
    assign eff_vcnt = begin_prim ? 2'd0 : vcnt;
    assign eff_par  = begin_prim ? 1'b0 : par;

    always_comb begin
        push              = 1'b0;
        push_entry.nverts = 2'd0;
        push_entry.data   = '0;
        v0_n              = v0;
        v1_n              = v1;
        vcnt_n            = eff_vcnt;
        par_n             = eff_par;
        if (accept) begin
            case (eff_mode)
                M_POINTS: begin
                    push              = 1'b1;
                    push_entry.nverts = 2'd1;
                    push_entry.data   = {{(2*SW){1'b0}}, vtx};
                    vcnt_n            = 2'd0;
                end
                M_LINES: begin
                    if (eff_vcnt == 2'd0) begin
                        v0_n   = vtx;
                        vcnt_n = 2'd1;
                    end else begin
                        push              = 1'b1;
                        push_entry.nverts = 2'd2;
                        push_entry.data   = {{SW{1'b0}}, vtx, v0};
                        vcnt_n            = 2'd0;
                    end
                end
                M_TRIS: begin
                    case (eff_vcnt)
                        2'd0: begin
                            v0_n   = vtx;
                            vcnt_n = 2'd1;
                        end
                        2'd1: begin
                            v1_n   = vtx;
                            vcnt_n = 2'd2;
                        end
                        default: begin
                            push              = 1'b1;
                            push_entry.nverts = 2'd3;
                            push_entry.data   = {vtx, v1, v0};
                            vcnt_n            = 2'd0;
                        end
                    endcase
                end
                default: begin
                    case (eff_vcnt)
                        2'd0: begin
                            v0_n   = vtx;
                            vcnt_n = 2'd1;
                        end
                        2'd1: begin
                            v1_n   = vtx;
                            vcnt_n = 2'd2;
                        end
                        default: begin
                            // odd strip triangles swap the older pair to keep winding
                            push              = 1'b1;
                            push_entry.nverts = 2'd3;
                            push_entry.data   = eff_par ? {vtx, v0, v1} : {vtx, v1, v0};
                            v0_n              = v1;
                            v1_n              = vtx;
                            par_n             = ~eff_par;
                            vcnt_n            = 2'd2;
                        end
                    endcase
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_r <= M_TRIS;
            v0     <= '0;
            v1     <= '0;
            vcnt   <= 2'd0;
            par    <= 1'b0;
        end else begin
            if (begin_prim)
                mode_r <= mode_t'(mode);
            v0   <= v0_n;
            v1   <= v1_n;
            vcnt <= vcnt_n;
            par  <= par_n;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= push_entry;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            prim_total <= 16'd0;
        end else begin
            if (push) begin
                wr_ptr     <= wr_ptr + 1'b1;
                prim_total <= prim_total + 16'd1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNTW'(1);
                2'b01:   fifo_count <= fifo_count - CNTW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // head is masked when empty so stale entries never leak out
    assign head        = mem[rd_ptr];
    assign prim_data   = prim_valid ? head.data   : '0;
    assign prim_nverts = prim_valid ? head.nverts : 2'd0;

endmodule

// File: tb/tb_gl_prim_assembler.sv
// Bench for gl_prim_assembler: directed scenarios plus random traffic against a
// queue-based primitive model.
module tb_gl_prim_assembler;
    localparam int PW    = 96;
    localparam int CW    = 96;
    localparam int DEPTH = 4;
    localparam int SW    = PW + CW;
    localparam int CNTW  = $clog2(DEPTH+1);
    localparam int XW    = 3*SW;

    typedef struct {
        logic [XW-1:0] data;
        logic [1:0]    n;
    } prim_t;

    logic              clk, reset;
    logic [1:0]        mode;
    logic              begin_prim, vert_valid, vert_ready;
    logic [PW-1:0]     vert_pos;
    logic [CW-1:0]     vert_color;
    logic              prim_valid, prim_ready;
    logic [XW-1:0]     prim_data;
    logic [1:0]        prim_nverts;
    logic [CNTW-1:0]   fifo_count;
    logic [15:0]       prim_total;

    gl_prim_assembler #(.PW(PW), .CW(CW), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .mode(mode), .begin_prim(begin_prim),
        .vert_valid(vert_valid), .vert_ready(vert_ready),
        .vert_pos(vert_pos), .vert_color(vert_color),
        .prim_valid(prim_valid), .prim_ready(prim_ready),
        .prim_data(prim_data), .prim_nverts(prim_nverts),
        .fifo_count(fifo_count), .prim_total(prim_total)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errs   = 0;
    int checks = 0;

    // reference model: open vertices of the current sequence and queued primitives
    int             m_mode;
    logic [SW-1:0]  part[$];
    bit             m_par;
    prim_t          q[$];
    logic [15:0]    m_tot;

    task automatic chk(input string tag, input logic [XW-1:0] got, input logic [XW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [SW-1:0] vx(input int n);
        logic [PW-1:0] p;
        logic [CW-1:0] c;
        p = PW'(n);
        c = CW'(n);
        return {p, c};
    endfunction

    task automatic model_reset();
        q.delete();
        part.delete();
        m_mode = 2;
        m_par  = 1'b0;
        m_tot  = 16'd0;
    endtask

    task automatic check_all();
        chk("prim_valid", XW'(prim_valid), XW'(q.size() != 0));
        chk("vert_ready", XW'(vert_ready), XW'(q.size() != DEPTH));
        chk("fifo_count", XW'(fifo_count), XW'(q.size()));
        chk("prim_total", XW'(prim_total), XW'(m_tot));
        if (q.size() != 0) begin
            chk("prim_data", prim_data, q[0].data);
            chk("prim_nverts", XW'(prim_nverts), XW'(q[0].n));
        end
    endtask

    // drive one cycle, predict its edge, then check after the edge
    task automatic tick(input bit bp, input logic [1:0] md, input bit vv,
                        input logic [SW-1:0] v, input bit pr, output bit acc);
        bit    pp, np;
        prim_t e;
        begin_prim = bp;
        mode       = md;
        vert_valid = vv;
        {vert_pos, vert_color} = v;
        prim_ready = pr;
        acc = vv && (q.size() != DEPTH);
        pp  = pr && (q.size() != 0);
        np  = 1'b0;
        e.data = '0;
        e.n    = 2'd0;
        if (bp) begin
            m_mode = int'(md);
            part.delete();
            m_par = 1'b0;
        end
        if (acc) begin
            part.push_back(v);
            case (m_mode)
                0: begin
                    np = 1'b1; e.n = 2'd1; e.data = {{(2*SW){1'b0}}, v};
                    part.delete();
                end
                1: if (part.size() == 2) begin
                    np = 1'b1; e.n = 2'd2; e.data = {{SW{1'b0}}, part[1], part[0]};
                    part.delete();
                end
                2: if (part.size() == 3) begin
                    np = 1'b1; e.n = 2'd3; e.data = {part[2], part[1], part[0]};
                    part.delete();
                end
                default: if (part.size() == 3) begin
                    np = 1'b1; e.n = 2'd3;
                    e.data = m_par ? {part[2], part[0], part[1]} : {part[2], part[1], part[0]};
                    void'(part.pop_front());
                    m_par = !m_par;
                end
            endcase
        end
        if (pp) void'(q.pop_front());
        if (np) begin
            q.push_back(e);
            m_tot = m_tot + 16'd1;
        end
        @(negedge clk);
        check_all();
    endtask

    task automatic send(input bit bp, input logic [1:0] md, input logic [SW-1:0] v, input bit pr);
        bit a;
        int k;
        k = 0;
        do begin
            tick(bp, md, 1'b1, v, pr, a);
            k++;
        end while (!a && k < 50);
        if (!a) chk("send_timeout", XW'(a), XW'(1));
    endtask

    task automatic idle(input int n, input bit pr);
        bit a;
        for (int i = 0; i < n; i++) tick(1'b0, 2'd0, 1'b0, '0, pr, a);
    endtask

    initial begin
        bit            a;
        logic [SW-1:0] rv;
        reset = 1'b1;
        begin_prim = 1'b0; mode = 2'd0; vert_valid = 1'b0;
        vert_pos = '0; vert_color = '0; prim_ready = 1'b0;
        model_reset();
        #12;
        chk("rst_valid",  XW'(prim_valid),  XW'(0));
        chk("rst_ready",  XW'(vert_ready),  XW'(1));
        chk("rst_data",   prim_data,        '0);
        chk("rst_nverts", XW'(prim_nverts), XW'(0));
        chk("rst_count",  XW'(fifo_count),  XW'(0));
        chk("rst_total",  XW'(prim_total),  XW'(0));
        @(negedge clk);
        reset = 1'b0;

        // default triangle mode with no begin_prim
        for (int i = 1; i <= 3; i++) send(1'b0, 2'd0, vx(i), 1'b1);
        chk("t1_valid", XW'(prim_valid), XW'(1));
        chk("t1_data",  prim_data, {vx(3), vx(2), vx(1)});
        chk("t1_total", XW'(prim_total), XW'(1));
        idle(2, 1'b1);

        // strip; mode input wiggles without begin_prim must be ignored
        send(1'b1, 2'd3, vx(1), 1'b1);
        for (int i = 2; i <= 5; i++) send(1'b0, 2'(i), vx(i), 1'b1);
        idle(3, 1'b1);

        // points into a stalled consumer until full
        send(1'b1, 2'd0, vx(1), 1'b0);
        for (int i = 2; i <= 4; i++) send(1'b0, 2'd0, vx(i), 1'b0);
        chk("t3_ready", XW'(vert_ready), XW'(0));
        chk("t3_count", XW'(fifo_count), XW'(DEPTH));
        send(1'b0, 2'd0, vx(5), 1'b1);
        idle(6, 1'b1);

        // lines with a restart on the second vertex
        send(1'b1, 2'd1, vx(1), 1'b1);
        send(1'b1, 2'd1, vx(2), 1'b1);
        chk("t4_none", XW'(prim_valid), XW'(0));
        send(1'b0, 2'd1, vx(3), 1'b1);
        chk("t4_data",   prim_data, {{SW{1'b0}}, vx(3), vx(2)});
        chk("t4_nverts", XW'(prim_nverts), XW'(2));
        idle(2, 1'b1);

        // simultaneous push and pop with two entries held, wrapping pointers
        send(1'b1, 2'd0, vx(10), 1'b0);
        send(1'b0, 2'd0, vx(11), 1'b0);
        for (int i = 0; i < 3*DEPTH; i++) begin
            send(1'b0, 2'd0, vx(20+i), 1'b1);
            chk("t5_count", XW'(fifo_count), XW'(2));
        end
        idle(4, 1'b1);

        // asynchronous reset mid-strip with three primitives queued
        send(1'b1, 2'd3, vx(1), 1'b0);
        for (int i = 2; i <= 5; i++) send(1'b0, 2'd3, vx(i), 1'b0);
        chk("t6_count_pre", XW'(fifo_count), XW'(3));
        #2 reset = 1'b1;
        #1;
        chk("t6_valid", XW'(prim_valid), XW'(0));
        chk("t6_count", XW'(fifo_count), XW'(0));
        chk("t6_total", XW'(prim_total), XW'(0));
        chk("t6_ready", XW'(vert_ready), XW'(1));
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        for (int i = 7; i <= 9; i++) send(1'b0, 2'd0, vx(i), 1'b0);
        chk("t6_data", prim_data, {vx(9), vx(8), vx(7)});
        idle(2, 1'b1);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            rv = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            tick(($urandom_range(7) == 0), 2'($urandom_range(3)),
                 ($urandom_range(9) < 7), rv, ($urandom_range(9) < 5), a);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/gl_prim_assembler.md
Name: gl_prim_assembler

Overview:
- Parametrised primitive-assembly and buffering stage between the viewport transform (clk1 domain) and the raster front end.
- Accepts a stream of transformed vertices, each a screen position plus an RGB color.
- Groups them into points, lines, independent triangles or triangle strips according to a selectable mode.
- Queues completed primitives in a DEPTH-entry FIFO with valid/ready handshakes on both sides.

Parameters:
- PW, 96, vertex position width ({x,y,z}, 32 bits each).
- CW, 96, vertex color width ({r,g,b}, 32 bits each).
- DEPTH, 4, number of primitive entries in the output FIFO (>=2, power of two).
- SW, PW+CW, derived slot width; not to be overridden.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- mode  in  2  primitive mode, sampled only on begin_prim: 0=points, 1=lines, 2=triangles, 3=triangle strip.
- begin_prim  in  1  start a new primitive sequence; discards any partial vertices.
- vert_valid  in  1  upstream vertex valid.
- vert_ready  out  1  stage can accept a vertex.
- vert_pos  in  PW  vertex position.
- vert_color  in  CW  vertex color.
- prim_valid  out  1  FIFO head valid.
- prim_ready  in  1  downstream consumes the head.
- prim_data  out  3*SW  {slot2,slot1,slot0}; each slot is {pos,color}, pos in the upper bits; unused slots are zero.
- prim_nverts  out  2  vertex count of the head primitive (1, 2 or 3).
- fifo_count  out  $clog2(DEPTH+1)  FIFO occupancy.
- prim_total  out  16  count of primitives pushed, wraps at 16'hFFFF->0.

Behaviour:
- Handshake definitions:
  - accept = vert_valid & vert_ready.
  - pop = prim_valid & prim_ready.
  - vert_ready = (fifo_count != DEPTH), combinational from registered count.
  - prim_valid = (fifo_count != 0).
  - prim_data and prim_nverts are driven combinationally from the head entry.
- Assembly state:
  - Registered mode_r, vertex registers v0 and v1 (SW each), vertex counter vcnt (0..2), strip parity bit par.
  - begin_prim loads mode_r <= mode, vcnt <= 0, par <= 0.
  - begin_prim asserted in the same cycle as accept: begin_prim applies first, and the accepted vertex becomes vertex 0 of the new sequence.
- Mode rules on accept (V = {vert_pos, vert_color}):
  - points: push {0,0,V}, nverts=1; vcnt stays 0.
  - lines, vcnt=0: v0<=V, vcnt<=1.
  - lines, vcnt=1: push {0,V,v0}, nverts=2, vcnt<=0.
  - triangles, vcnt=0: v0<=V, vcnt<=1.
  - triangles, vcnt=1: v1<=V, vcnt<=2.
  - triangles, vcnt=2: push {V,v1,v0}, nverts=3, vcnt<=0.
  - strip, vcnt=0: v0<=V, vcnt<=1.
  - strip, vcnt=1: v1<=V, vcnt<=2.
  - strip, vcnt=2:
    - push {V,v1,v0} if par=0, else {V,v0,v1} (preserves winding);
    - then v0<=v1, v1<=V, par<=~par; vcnt stays 2.
- FIFO:
  - Circular array of DEPTH entries, each 3*SW+2 bits; write and read pointers wrap modulo DEPTH.
  - Push only occurs on an accept that completes a primitive. Because vert_ready is low when full, no push is ever attempted when full.
  - Push and pop in the same cycle: both pointers advance and fifo_count is unchanged.
  - Pop when empty is impossible because prim_valid is low.
- Latency and counters:
  - A vertex accepted at edge N that completes a primitive is visible at the head after edge N if the FIFO was empty (one-cycle latency).
  - Full-to-ready: a pop at edge N raises vert_ready after edge N.
  - prim_total increments by 1 on every push.
- mode input changes without begin_prim are ignored.
- Asynchronous reset, effective immediately (including mid-primitive or with a non-empty FIFO):
  - fifo_count=0, pointers=0, vcnt=0, par=0, mode_r=2 (triangles), v0=v1=0, prim_total=0.
  - Outputs: prim_valid=0, vert_ready=1, prim_data=0, prim_nverts=0.
  - Partial vertices and queued primitives are discarded.

Test Plan:
- Vertex labelling used below: vertex n has pos=color=n zero-extended.
- Reset, then mode=2 with no begin_prim; send vertices 1,2,3 with prim_ready=1 -> one primitive, slots {3,2,1}, nverts=3, prim_total=1, prim_valid high the cycle after vertex 3 is accepted.
- begin_prim with mode=3; send vertices 1..5 -> three primitives: {3,2,1}, {4,2,3}, {5,4,3}, each nverts=3.
- begin_prim with mode=0; prim_ready=0; send vertices 1..5 -> vert_ready drops after the 4th accept, fifo_count=4. Then raise prim_ready -> heads pop in order 1,2,3,4, and vertex 5 is accepted after the first pop.
- begin_prim with mode=1; send vertices 1 and 2, with begin_prim asserted alongside vertex 2 -> no primitive; vertex 2 becomes vertex 0. Then send 3 -> {0,3,2}, nverts=2.
- FIFO holding 2 entries, with accept-completing-a-point and pop in the same cycle -> fifo_count stays 2, pointers wrap correctly over 3*DEPTH pushes, and data order is preserved.
- Assert reset mid-strip with 3 entries queued -> prim_valid=0, fifo_count=0, prim_total=0 immediately. After release, vertices 7,8,9 in default triangle mode -> {9,8,7}.
